uart_cmd_rx: RTL
================

# uart_cmd_rx

Serial receive front end for the analyzer's host link. Deserialises 8N1 UART frames from `uart_rx` and assembles them into SUMP-style commands. A short command is one opcode byte with MSB=0. A long command is an opcode byte with MSB=1 followed by four data bytes. Each completed command is presented to the command decoder as opcode plus 32-bit data with a one-cycle `execute` strobe. It is the receive-side counterpart of `uart_tx` and shares its FREQ/BAUDRATE/BITLENGTH parameters.

## Interface
- `FREQ`, 100000000, system clock frequency in Hz
- `BAUDRATE`, 115200, line rate in baud
- `BITLENGTH`, FREQ/BAUDRATE, clocks per bit; must be ≥ 4
- `clock`  in  1  system clock; everything is in this domain except `uart_rx`
- `reset`  in  1  reset, asynchronous, active-high; clock clock
- `uart_rx`  in  1  serial line, asynchronous, idles high
- `opcode`  out  8  opcode of the last completed command; reset 8'h00
- `data`  out  32  data of the last completed long command; byte 1 in [7:0], byte 4 in [31:24]; reset 32'h0
- `execute`  out  1  one-cycle strobe, command complete; reset 0
- `framing_error`  out  1  one-cycle strobe, stop bit sampled low; reset 0

## Operation
- **Synchroniser:** `uart_rx` passes through 2 flops, reset to 1. Call the output `rxs`. All logic uses `rxs` only.
- **Bit FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **Bit counter:** counts down; width = clog2(BITLENGTH)+1.
  - **IDLE:** when `rxs`=0, load counter with BITLENGTH/2 (integer divide) and go to START.
  - **START:** at counter zero, sample `rxs`.
    - 1: glitch; return to IDLE with no output.
    - 0: load BITLENGTH-1, clear the bit index, go to DATA.
  - **DATA:** at each counter zero, shift `rxs` into the shift register LSB-first and reload BITLENGTH-1. After the 8th bit, go to STOP.
  - **STOP:** at counter zero, sample `rxs`.
    - 1: byte valid; go to IDLE.
    - 0: pulse `framing_error`, discard the byte, go to BREAK.
  - **BREAK:** wait for `rxs`=1, then go to IDLE. A held-low line produces exactly one `framing_error`.
- **Command assembler states:** OPCODE, ARGS (byte index 0–3).
  - In OPCODE, a valid byte is latched into a pending-opcode register.
    - MSB=0: on the next cycle, update `opcode`, leave `data` unchanged, pulse `execute`.
    - MSB=1: go to ARGS with index 0.
  - In ARGS, the valid byte with index i is written into pending-data bits [8i+7:8i].
    - After index 3: update `opcode` and `data` together, pulse `execute`, return to OPCODE.
  - Any `framing_error` forces the assembler to OPCODE and discards the partial command.
- **Output stability:** `opcode`/`data` change only in the cycle `execute` is high, and hold until the next `execute`.
- **No inter-byte timeout:** the host resynchronises by sending five 0x00 bytes. Each 0x00 is a short command, so at most one partial long command is absorbed.

## Timing
- Line to FSM latency: 2 clocks (synchroniser).
- Start-bit falling edge at `rxs` (cycle T0) → START sample at T0+BITLENGTH/2+1. Data bit k is sampled BITLENGTH clocks apart, i.e. mid-bit.
- `execute` is high exactly one cycle, on the clock after the stop-bit sample of the final byte.
- Back-to-back frames need no idle gap: the FSM is back in IDLE on the cycle after the stop sample, which is about half a bit before the stop-bit end.
- `execute` and `framing_error` are never high in the same cycle.
- **Asynchronous reset mid-frame:**
  - All outputs go to their reset values immediately.
  - Both FSMs return to IDLE/OPCODE.
  - The synchroniser is preset to 1, so a frame already in progress is not treated as a start edge until `rxs` next falls.

## Structure
- **Shared package constants:**
  - bit-FSM state encodings (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK)
  - assembler states (CMD_OPCODE, CMD_ARGS)
  - LONG_CMD_MASK = 8'h80
  - SUMP opcode constants (CMD_RESET=8'h00, CMD_RUN=8'h01, CMD_ID=8'h02, CMD_XON=8'h11, CMD_XOFF=8'h13) for the downstream decoder
- **One sub-module:** `uart_rx_byte` (synchroniser plus bit FSM; outputs `byte_valid`, `byte_data[7:0]`, `framing_error`). The assembler lives in `uart_cmd_rx`.

## Test plan
Bench parameters: FREQ=1000000, BAUDRATE=100000, so BITLENGTH=10.
- **Short command:** send 0x02 → one `execute` with `opcode`=8'h02 and `data` unchanged (32'h0 after reset); no `framing_error`.
- **Long command:** send 0xC0,0x78,0x56,0x34,0x12 back-to-back with no idle gaps → exactly one `execute`, `opcode`=8'hC0, `data`=32'h12345678, at the 5th stop-bit sample +1.
- **Glitch:** drive a 3-clock low pulse on an idle line → no `execute`, no `framing_error`, FSM back in IDLE.
- **Framing error:** send 0x81,0xAA, then a frame with stop=0, then 0x11 → one `framing_error`; next `execute` shows `opcode`=8'h11 with `data` unchanged.
- **Break:** hold the line low for 50 bit times, then send 0x13 → one `framing_error`, then `execute` with `opcode`=8'h13.
- **Reset mid-command:** assert `reset` during the 3rd byte of a long command, release, send 0x01 → outputs zero during reset; then `execute` with `opcode`=8'h01 and `data`=32'h0.

Source files
------------

// File: rtl/uart_cmd_rx_pkg.sv
// Shared types and constants for the host-link receive path and the
// downstream SUMP command decoder.
package uart_cmd_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic {
    CMD_OPCODE,
    CMD_ARGS
  } cmd_state_e;

  // An opcode with this bit set is followed by four argument bytes
  localparam logic [7:0] LONG_CMD_MASK = 8'h80;

  localparam logic [7:0] CMD_RESET = 8'h00;
  localparam logic [7:0] CMD_RUN   = 8'h01;
  localparam logic [7:0] CMD_ID    = 8'h02;
  localparam logic [7:0] CMD_XON   = 8'h11;
  localparam logic [7:0] CMD_XOFF  = 8'h13;

endpackage

// File: rtl/uart_rx_byte.sv
// Two-flop synchroniser plus 8N1 bit FSM; emits a one-cycle byte_valid or
// framing_error strobe in the cycle the stop bit is sampled.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int BITLENGTH = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_error
);

  localparam int CW = $clog2(BITLENGTH) + 1;
  localparam logic [CW-1:0] HALF_BIT = CW'(BITLENGTH / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(BITLENGTH - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  logic          countZero;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;

  // Preset to idle-high so a reset mid-frame cannot fake a start edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rx};
    end
  end

  assign rxs       = sync_q[1];
  assign countZero = (count_q == '0);
  assign byte_data = shift_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= RX_IDLE;
      count_q  <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    bitIdx_d      = bitIdx_q;
    shift_d       = shift_q;
    byte_valid    = 1'b0;
    framing_error = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rxs) begin
          count_d = HALF_BIT;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (!countZero) begin
          count_d = count_q - 1'b1;
        end else if (rxs) begin
          state_d = RX_IDLE;
        end else begin
          count_d  = FULL_BIT;
          bitIdx_d = '0;
          state_d  = RX_DATA;
        end
      end
      RX_DATA: begin
        if (!countZero) begin
          count_d = count_q - 1'b1;
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          count_d = FULL_BIT;
          if (bitIdx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (!countZero) begin
          count_d = count_q - 1'b1;
        end else if (rxs) begin
          byte_valid = 1'b1;
          state_d    = RX_IDLE;
        end else begin
          framing_error = 1'b1;
          state_d       = RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host-link receive front end: turns UART bytes into SUMP short/long
// commands presented as opcode + 32-bit data with a one-cycle execute strobe.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int FREQ      = 100000000,
  parameter int BAUDRATE  = 115200,
  parameter int BITLENGTH = FREQ / BAUDRATE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  output logic [7:0]  opcode,
  output logic [31:0] data,
  output logic        execute,
  output logic        framing_error
);

  logic        byteValid;
  logic [7:0]  byteData;
  logic        rxFramingError;

  cmd_state_e  cmdState_q, cmdState_d;
  logic [1:0]  argIdx_q, argIdx_d;
  logic [7:0]  pendOpcode_q, pendOpcode_d;
  logic [23:0] pendData_q, pendData_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [31:0] data_q, data_d;
  logic        execute_q, execute_d;
  logic        framingError_q, framingError_d;

  uart_rx_byte #(
    .BITLENGTH(BITLENGTH)
  ) rxByte (
    .clock        (clock),
    .reset        (reset),
    .uart_rx      (uart_rx),
    .byte_valid   (byteValid),
    .byte_data    (byteData),
    .framing_error(rxFramingError)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmdState_q     <= CMD_OPCODE;
      argIdx_q       <= '0;
      pendOpcode_q   <= '0;
      pendData_q     <= '0;
      opcode_q       <= '0;
      data_q         <= '0;
      execute_q      <= 1'b0;
      framingError_q <= 1'b0;
    end else begin
      cmdState_q     <= cmdState_d;
      argIdx_q       <= argIdx_d;
      pendOpcode_q   <= pendOpcode_d;
      pendData_q     <= pendData_d;
      opcode_q       <= opcode_d;
      data_q         <= data_d;
      execute_q      <= execute_d;
      framingError_q <= framingError_d;
    end
  end

  // Published opcode/data only move together with execute
  always_comb begin
    cmdState_d     = cmdState_q;
    argIdx_d       = argIdx_q;
    pendOpcode_d   = pendOpcode_q;
    pendData_d     = pendData_q;
    opcode_d       = opcode_q;
    data_d         = data_q;
    execute_d      = 1'b0;
    framingError_d = rxFramingError;
    if (rxFramingError) begin
      cmdState_d = CMD_OPCODE;
    end else if (byteValid) begin
      case (cmdState_q)
        CMD_OPCODE: begin
          pendOpcode_d = byteData;
          if ((byteData & LONG_CMD_MASK) != 8'h00) begin
            argIdx_d   = '0;
            cmdState_d = CMD_ARGS;
          end else begin
            opcode_d  = byteData;
            execute_d = 1'b1;
          end
        end
        CMD_ARGS: begin
          if (argIdx_q == 2'd3) begin
            opcode_d   = pendOpcode_q;
            data_d     = {byteData, pendData_q};
            execute_d  = 1'b1;
            cmdState_d = CMD_OPCODE;
          end else begin
            case (argIdx_q)
              2'd0:    pendData_d[7:0]   = byteData;
              2'd1:    pendData_d[15:8]  = byteData;
              default: pendData_d[23:16] = byteData;
            endcase
            argIdx_d = argIdx_q + 2'd1;
          end
        end
        default: begin
          cmdState_d = CMD_OPCODE;
        end
      endcase
    end
  end

  assign opcode        = opcode_q;
  assign data          = data_q;
  assign execute       = execute_q;
  assign framing_error = framingError_q;

endmodule
